// File: rtl/wb_arbiter.sv
// Write-back arbiter: queues ALU/load write-backs in order and owns the register file write port.
// Optional WB_BYPASS_EN adds fwd_data1/fwd_data2 carrying the youngest pending value per checked register.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [4:0]  mem_reg,
    input  logic [31:0] mem_data,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [4:0]  alu_reg,
    input  logic [31:0] alu_data,
    output logic        reg_write,
    output logic [4:0]  write_register,
    output logic [31:0] write_data,
    input  logic [4:0]  chk_reg1,
    input  logic [4:0]  chk_reg2,
    output logic        busy1,
    output logic        busy2
`ifdef WB_BYPASS_EN
    ,
    output logic [31:0] fwd_data1,
    output logic [31:0] fwd_data2
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    regQ  [DEPTH];
    logic [31:0]   dataQ [DEPTH];
    logic [PW-1:0] rdPtr, wrPtr, aluSlot;
    logic [CW-1:0] count, freeSlots;
    logic          memPush, aluPush, pop;

    // Readiness looks only at the registered count; a same-cycle drain is not credited.
    assign freeSlots = CW'(DEPTH) - count;
    assign mem_ready = (freeSlots != '0);
    assign alu_ready = (freeSlots >= CW'(2)) | ((freeSlots != '0) & !mem_valid);

    // Writes to r0 complete the handshake but never occupy a slot.
    assign memPush = mem_valid & mem_ready & (mem_reg != 5'd0);
    assign aluPush = alu_valid & alu_ready & (alu_reg != 5'd0);
    assign pop     = (count != '0);
    assign aluSlot = wrPtr + PW'(memPush);

    // Queue storage needs no reset: only entries inside count are ever observed.
    always_ff @(posedge clk) begin
        if (memPush) begin
            regQ[wrPtr]  <= mem_reg;
            dataQ[wrPtr] <= mem_data;
        end
        if (aluPush) begin
            regQ[aluSlot]  <= alu_reg;
            dataQ[aluSlot] <= alu_data;
        end
    end

    // Pointers, occupancy and the registered write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdPtr          <= '0;
            wrPtr          <= '0;
            count          <= '0;
            reg_write      <= 1'b0;
            write_register <= 5'd0;
            write_data     <= 32'd0;
        end else begin
            rdPtr <= rdPtr + PW'(pop);
            wrPtr <= wrPtr + PW'(memPush) + PW'(aluPush);
            count <= count + CW'(memPush) + CW'(aluPush) - CW'(pop);
            if (pop) begin
                reg_write      <= 1'b1;
                write_register <= regQ[rdPtr];
                write_data     <= dataQ[rdPtr];
            end else begin
                reg_write <= 1'b0;
            end
        end
    end

    logic [4:0]    chkReg [2];
    logic          hit    [2];
    logic [PW-1:0] idx;
`ifdef WB_BYPASS_EN
    logic [31:0]   fwd    [2];
`endif

    assign chkReg[0] = chk_reg1;
    assign chkReg[1] = chk_reg2;

    // Scan oldest to youngest so the last match (nearest wrPtr) supplies the forwarded value;
    // the output stage counts as older than every queued entry.
    always_comb begin
        idx = '0;
        for (int n = 0; n < 2; n++) begin
            hit[n] = 1'b0;
`ifdef WB_BYPASS_EN
            fwd[n] = 32'd0;
`endif
            if (reg_write && (write_register == chkReg[n])) begin
                hit[n] = 1'b1;
`ifdef WB_BYPASS_EN
                fwd[n] = write_data;
`endif
            end
            for (int k = 0; k < DEPTH; k++) begin
                idx = rdPtr + PW'(k);
                if ((CW'(k) < count) && (regQ[idx] == chkReg[n])) begin
                    hit[n] = 1'b1;
`ifdef WB_BYPASS_EN
                    fwd[n] = dataQ[idx];
`endif
                end
            end
            if (chkReg[n] == 5'd0) begin
                hit[n] = 1'b0;
`ifdef WB_BYPASS_EN
                fwd[n] = 32'd0;
`endif
            end
        end
    end

    assign busy1 = hit[0];
    assign busy2 = hit[1];
`ifdef WB_BYPASS_EN
    assign fwd_data1 = fwd[0];
    assign fwd_data2 = fwd[1];
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed vector table, reset-during-traffic sequence, then random
// traffic checked against a queue-based reference model.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_reg, alu_reg, chk_reg1, chk_reg2;
    logic [31:0] mem_data, alu_data;
    logic        reg_write, busy1, busy2;
    logic [4:0]  write_register;
    logic [31:0] write_data;
`ifdef WB_BYPASS_EN
    logic [31:0] fwd_data1, fwd_data2;
`endif

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .reg_write(reg_write), .write_register(write_register), .write_data(write_data),
        .chk_reg1(chk_reg1), .chk_reg2(chk_reg2), .busy1(busy1), .busy2(busy2)
`ifdef WB_BYPASS_EN
        , .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mv;
        logic [4:0]  mr;
        logic [31:0] md;
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic [4:0]  c1;
        logic [4:0]  c2;
        logic        eMr;
        logic        eAr;
        logic        eB1;
        logic        eB2;
        logic        eRw;
        logic [4:0]  eWr;
        logic [31:0] eWd;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } entry_t;

    vec_t   vec [20];
    entry_t modelQ [$];
    logic        mRw;
    logic [4:0]  mReg;
    logic [31:0] mData;
    int checks = 0;
    int passes = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    endtask

    task automatic applyStimulus(input logic mv, input logic [4:0] mr, input logic [31:0] md,
                                 input logic av, input logic [4:0] ar, input logic [31:0] ad,
                                 input logic [4:0] c1, input logic [4:0] c2);
        @(negedge clk);
        mem_valid = mv; mem_reg = mr; mem_data = md;
        alu_valid = av; alu_reg = ar; alu_data = ad;
        chk_reg1 = c1; chk_reg2 = c2;
        #1;
    endtask

    function automatic logic modelBusy(input logic [4:0] c);
        if (c == 5'd0) return 1'b0;
        if (mRw && mReg == c) return 1'b1;
        foreach (modelQ[i]) if (modelQ[i].r == c) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] modelFwd(input logic [4:0] c);
        if (c == 5'd0) return 32'd0;
        for (int i = modelQ.size() - 1; i >= 0; i--) if (modelQ[i].r == c) return modelQ[i].d;
        if (mRw && mReg == c) return mData;
        return 32'd0;
    endfunction

    task automatic modelEdge(input logic memAcc, input logic aluAcc);
        entry_t e;
        if (modelQ.size() > 0) begin
            e = modelQ.pop_front();
            mRw = 1'b1; mReg = e.r; mData = e.d;
        end else begin
            mRw = 1'b0;
        end
        if (memAcc && mem_reg != 5'd0) modelQ.push_back('{mem_reg, mem_data});
        if (aluAcc && alu_reg != 5'd0) modelQ.push_back('{alu_reg, alu_data});
    endtask

    initial begin
        vec[0]  = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0};
        vec[1]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0};
        vec[2]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
        vec[3]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vec[4]  = '{1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22, 5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vec[5]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
        vec[6]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
        vec[7]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd3, 32'h22};
        vec[8]  = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd3, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h22};
        vec[9]  = '{1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd3, 32'h22};
        vec[10] = '{1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 5'd3, 32'h22};
        vec[11] = '{1'b1, 5'd7, 32'hA7, 1'b1, 5'd8, 32'hA8, 5'd1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'hA1};
        vec[12] = '{1'b1, 5'd9, 32'hA9, 1'b1, 5'd8, 32'hA8, 5'd8, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'hA2};
        vec[13] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd8, 32'hA8, 5'd8, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'hA4};
        vec[14] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd8, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd6, 32'hA6};
        vec[15] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd9, 5'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd7, 32'hA7};
        vec[16] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'hA9};
        vec[17] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'hA8};
        vec[18] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'hA8};
        vec[19] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,  5'd0, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'hA8};

        rst = 1'b1;
        mem_valid = 1'b0; mem_reg = 5'd0; mem_data = 32'd0;
        alu_valid = 1'b0; alu_reg = 5'd0; alu_data = 32'd0;
        chk_reg1 = 5'd0; chk_reg2 = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset memReady", 32'(mem_ready), 32'd1);
        checkOutput("reset aluReady", 32'(alu_ready), 32'd1);
        checkOutput("reset regWrite", 32'(reg_write), 32'd0);
        checkOutput("reset writeRegister", 32'(write_register), 32'd0);
        checkOutput("reset writeData", write_data, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            applyStimulus(vec[i].mv, vec[i].mr, vec[i].md, vec[i].av, vec[i].ar, vec[i].ad, vec[i].c1, vec[i].c2);
            checkOutput($sformatf("vec%0d memReady", i), 32'(mem_ready), 32'(vec[i].eMr));
            checkOutput($sformatf("vec%0d aluReady", i), 32'(alu_ready), 32'(vec[i].eAr));
            checkOutput($sformatf("vec%0d busy1", i), 32'(busy1), 32'(vec[i].eB1));
            checkOutput($sformatf("vec%0d busy2", i), 32'(busy2), 32'(vec[i].eB2));
            checkOutput($sformatf("vec%0d regWrite", i), 32'(reg_write), 32'(vec[i].eRw));
            checkOutput($sformatf("vec%0d writeRegister", i), 32'(write_register), 32'(vec[i].eWr));
            checkOutput($sformatf("vec%0d writeData", i), write_data, vec[i].eWd);
`ifdef WB_BYPASS_EN
            if (i == 5) checkOutput("vec5 fwdData1", fwd_data1, 32'h22);
`endif
        end

        // Reset asserted between edges with three entries queued and a write on the port.
        applyStimulus(1'b1, 5'd10, 32'hB0, 1'b1, 5'd11, 32'hB1, 5'd11, 5'd12);
        applyStimulus(1'b1, 5'd12, 32'hB2, 1'b1, 5'd13, 32'hB3, 5'd11, 5'd12);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12);
        checkOutput("preReset regWrite", 32'(reg_write), 32'd1);
        checkOutput("preReset aluReady", 32'(alu_ready), 32'd1);
        checkOutput("preReset busy2", 32'(busy2), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncReset regWrite", 32'(reg_write), 32'd0);
        checkOutput("asyncReset writeRegister", 32'(write_register), 32'd0);
        checkOutput("asyncReset writeData", write_data, 32'd0);
        checkOutput("asyncReset busy1", 32'(busy1), 32'd0);
        checkOutput("asyncReset busy2", 32'(busy2), 32'd0);
        checkOutput("asyncReset memReady", 32'(mem_ready), 32'd1);
        checkOutput("asyncReset aluReady", 32'(alu_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd13);
            checkOutput($sformatf("postReset%0d regWrite", i), 32'(reg_write), 32'd0);
            checkOutput($sformatf("postReset%0d busy", i), 32'({busy1, busy2}), 32'd0);
        end

        modelQ.delete();
        mRw = 1'b0; mReg = 5'd0; mData = 32'd0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  freeN;
            logic eMr, eAr;
            applyStimulus($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom(),
                          $urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom(),
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            freeN = DEPTH - modelQ.size();
            eMr = (freeN >= 1);
            eAr = (freeN >= 2) || (freeN >= 1 && !mem_valid);
            checkOutput("rand memReady", 32'(mem_ready), 32'(eMr));
            checkOutput("rand aluReady", 32'(alu_ready), 32'(eAr));
            checkOutput("rand busy1", 32'(busy1), 32'(modelBusy(chk_reg1)));
            checkOutput("rand busy2", 32'(busy2), 32'(modelBusy(chk_reg2)));
            checkOutput("rand regWrite", 32'(reg_write), 32'(mRw));
            checkOutput("rand writeRegister", 32'(write_register), 32'(mReg));
            checkOutput("rand writeData", write_data, mData);
`ifdef WB_BYPASS_EN
            checkOutput("rand fwdData1", fwd_data1, modelFwd(chk_reg1));
            checkOutput("rand fwdData2", fwd_data2, modelFwd(chk_reg2));
`endif
            @(posedge clk);
            modelEdge(mem_valid && eMr, alu_valid && eAr);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
